// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
// Shared constants for the register-file writeback arbiter: default widths,
// requester count, requester index names and the INIT/RUN state encoding.
package regfile_wb_arbiter_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREQ = 3;

  // Requester slots on the writeback port
  localparam int REQ_ALU   = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_DEBUG = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter
// Round-robin picker. Scans the request vector starting at ptr, wrapping
// modulo NREQ, and grants the first asserted request.
// Ports:
//   req         - request vector, one bit per requester
//   ptr         - index where the scan starts (always < NREQ)
//   grant       - one-hot grant, zero when nothing requests
//   grant_idx   - index of the granted requester
//   grant_valid - high when any request was granted
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_valid
);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = PW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates several writeback requesters onto a single register-file write
// port. After reset it sweeps addresses 1..2^AW-1 writing zero, then grants
// requesters round-robin and forwards each accepted write one cycle later.
// Writes to address 0 complete the handshake but are suppressed and counted.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   req_valid   - per-requester write pending
//   req_waddr   - packed per-requester addresses, [i*AW +: AW]
//   req_wdata   - packed per-requester data, [i*DW +: DW]
//   req_ready   - one-hot grant for this cycle (zero in INIT / reset)
//   reg_wr      - register-file write enable
//   waddr       - register-file write address
//   wdata       - register-file write data
//   init_done   - clear sweep finished
//   grant_id    - index of the last accepted requester
//   x0_drops    - saturating count of suppressed address-0 writes
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
  parameter int AW   = regfile_wb_arbiter_pkg::AW,
  parameter int DW   = regfile_wb_arbiter_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic              reg_wr,
  output logic [AW-1:0]     waddr,
  output logic [DW-1:0]     wdata,
  output logic              init_done,
  output logic [1:0]        grant_id,
  output logic [7:0]        x0_drops
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW-1:0] SWEEP_LAST = {AW{1'b1}};
  localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);

  wb_state_t       state, state_next;
  logic [AW-1:0]   sweep_cnt;
  logic [PW-1:0]   rr_ptr;
  logic            wr_q;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            grant_valid;
  logic            transfer;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_data;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign acc_addr = req_waddr[int'(grant_idx)*AW +: AW];
  assign acc_data = req_wdata[int'(grant_idx)*DW +: DW];

  // Masking with reset drops a registered write that is still on the port
  // when reset arrives, so it never lands in the register file.
  assign reg_wr = wr_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    transfer   = 1'b0;
    case (state)
      ST_INIT: begin
        if (sweep_cnt == SWEEP_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!reset) begin
          req_ready = grant;
          transfer  = grant_valid;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt <= AW'(1);
      rr_ptr    <= '0;
      wr_q      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      init_done <= 1'b0;
      grant_id  <= '0;
      x0_drops  <= '0;
    end else if (state == ST_INIT) begin
      wr_q      <= 1'b1;
      waddr     <= sweep_cnt;
      wdata     <= '0;
      sweep_cnt <= sweep_cnt + AW'(1);
      if (sweep_cnt == SWEEP_LAST) begin
        init_done <= 1'b1;
      end
    end else begin
      wr_q <= 1'b0;
      if (transfer) begin
        waddr    <= acc_addr;
        wdata    <= acc_data;
        grant_id <= 2'(grant_idx);
        rr_ptr   <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PW'(1);
        // Address 0 is hardwired in the register file: accept, but never write.
        if (acc_addr == '0) begin
          if (x0_drops != 8'hFF) begin
            x0_drops <= x0_drops + 8'd1;
          end
        end else begin
          wr_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter: reset state, the clear sweep, a
// table of single-cycle arbitration vectors, then hand-written sequences
// for collisions, address-0 suppression/saturation and reset mid-operation.
// A small register-file model captures writes from the output port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_waddr;
  logic [95:0] req_wdata;
  logic [2:0]  req_ready;
  logic        reg_wr;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        init_done;
  logic [1:0]  grant_id;
  logic [7:0]  x0_drops;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32] = '{default: 32'h0};

  always #5 clk = ~clk;

  // Downstream register file: captures whatever the port writes.
  always @(posedge clk) begin
    if (reg_wr) rf[waddr] <= wdata;
  end

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .reg_wr    (reg_wr),
    .waddr     (waddr),
    .wdata     (wdata),
    .init_done (init_done),
    .grant_id  (grant_id),
    .x0_drops  (x0_drops)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  exp_ready;
    logic        exp_wr;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_gid;
  } vec_t;

  vec_t vec [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2);
    req_valid = v;
    req_waddr = {a2, a1, a0};
    req_wdata = {d2, d1, d0};
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.valid, v.a0, v.a1, v.a2, v.d0, v.d1, v.d2);
  endtask

  localparam logic [31:0] DA = 32'hA0A0A0A0;
  localparam logic [31:0] DB = 32'hB1B1B1B1;
  localparam logic [31:0] DC = 32'hC2C2C2C2;

  initial begin
    // Expected values assume rr_ptr=0 at the first RUN cycle.
    vec[0]  = '{3'b010, 5'd0,  5'd5,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b1, 5'd5,  32'hDEADBEEF, 2'd1};
    vec[1]  = '{3'b000, 5'd0,  5'd5,  5'd0,  32'h0, 32'hDEADBEEF, 32'h0, 3'b000, 1'b0, 5'd5,  32'hDEADBEEF, 2'd1};
    vec[2]  = '{3'b100, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b100, 1'b1, 5'd13, DC, 2'd2};
    vec[3]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b001, 1'b1, 5'd11, DA, 2'd0};
    vec[4]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b010, 1'b1, 5'd12, DB, 2'd1};
    vec[5]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b100, 1'b1, 5'd13, DC, 2'd2};
    vec[6]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b001, 1'b1, 5'd11, DA, 2'd0};
    vec[7]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b010, 1'b1, 5'd12, DB, 2'd1};
    vec[8]  = '{3'b111, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b100, 1'b1, 5'd13, DC, 2'd2};
    vec[9]  = '{3'b110, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b010, 1'b1, 5'd12, DB, 2'd1};
    vec[10] = '{3'b011, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b001, 1'b1, 5'd11, DA, 2'd0};
    vec[11] = '{3'b101, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b100, 1'b1, 5'd13, DC, 2'd2};
    vec[12] = '{3'b000, 5'd11, 5'd12, 5'd13, DA, DB, DC, 3'b000, 1'b0, 5'd13, DC, 2'd2};

    // Reset with every requester asking
    reset = 1'b1;
    drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    tick();
    tick();
    check_output("rst_reg_wr",    32'(reg_wr),    32'h0);
    check_output("rst_waddr",     32'(waddr),     32'h0);
    check_output("rst_wdata",     wdata,          32'h0);
    check_output("rst_init_done", 32'(init_done), 32'h0);
    check_output("rst_grant_id",  32'(grant_id),  32'h0);
    check_output("rst_x0_drops",  32'(x0_drops),  32'h0);
    check_output("rst_req_ready", 32'(req_ready), 32'h0);

    // Clear sweep: addresses 1..31, data 0, no grants
    reset = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      #2;
      check_output("sweep_ready", 32'(req_ready), 32'h0);
      check_output("sweep_init_done", 32'(init_done), 32'h0);
      tick();
      check_output("sweep_reg_wr", 32'(reg_wr), 32'h1);
      check_output("sweep_waddr",  32'(waddr),  32'(i));
      check_output("sweep_wdata",  wdata,       32'h0);
    end
    check_output("init_done_set", 32'(init_done), 32'h1);

    // Table of single-cycle arbitration vectors
    for (int k = 0; k < 13; k++) begin
      apply_stimulus(vec[k]);
      #2;
      check_output($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vec[k].exp_ready));
      tick();
      check_output($sformatf("v%0d_reg_wr", k), 32'(reg_wr), 32'(vec[k].exp_wr));
      check_output($sformatf("v%0d_waddr", k),  32'(waddr),  32'(vec[k].exp_waddr));
      check_output($sformatf("v%0d_wdata", k),  wdata,       vec[k].exp_wdata);
      check_output($sformatf("v%0d_grant_id", k), 32'(grant_id), 32'(vec[k].exp_gid));
    end
    check_output("rf_addr5", rf[5], 32'hDEADBEEF);

    // Collision on address 3, rr_ptr=0: requester 0 first, then requester 1
    drive(3'b011, 5'd3, 5'd3, 5'd0, 32'hCAFEBABE, 32'h12345678, 32'h0);
    #2;
    check_output("col_ready0", 32'(req_ready), 32'h1);
    tick();
    check_output("col_wdata0", wdata, 32'hCAFEBABE);
    drive(3'b010, 5'd3, 5'd3, 5'd0, 32'hCAFEBABE, 32'h12345678, 32'h0);
    #2;
    check_output("col_ready1", 32'(req_ready), 32'h2);
    tick();
    check_output("col_rf3_first", rf[3], 32'hCAFEBABE);
    check_output("col_wdata1", wdata, 32'h12345678);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check_output("col_rf3_second", rf[3], 32'h12345678);

    // Address-0 suppression from requester 2 (rr_ptr=2 here), then saturation
    drive(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF);
    #2;
    check_output("x0_ready", 32'(req_ready), 32'h4);
    tick();
    check_output("x0_reg_wr", 32'(reg_wr), 32'h0);
    check_output("x0_drops1", 32'(x0_drops), 32'h1);
    check_output("x0_grant_id", 32'(grant_id), 32'h2);
    for (int i = 0; i < 299; i++) tick();
    check_output("x0_drops_sat", 32'(x0_drops), 32'hFF);
    check_output("x0_reg_wr_late", 32'(reg_wr), 32'h0);
    drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    check_output("rf_addr0", rf[0], 32'h0);

    // Reset the cycle after a transfer to address 7 (rr_ptr=0)
    drive(3'b001, 5'd7, 5'd0, 5'd0, 32'h77777777, 32'h0, 32'h0);
    #2;
    check_output("mid_ready", 32'(req_ready), 32'h1);
    tick();
    check_output("mid_waddr", 32'(waddr), 32'h7);
    reset = 1'b1;
    #2;
    check_output("mid_reg_wr_masked", 32'(reg_wr), 32'h0);
    check_output("mid_ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    check_output("mid_rf7", rf[7], 32'h0);
    check_output("mid_init_done", 32'(init_done), 32'h0);
    check_output("mid_x0_drops", 32'(x0_drops), 32'h0);
    reset = 1'b0;
    tick();
    check_output("restart_reg_wr", 32'(reg_wr), 32'h1);
    check_output("restart_waddr", 32'(waddr), 32'h1);
    tick();
    check_output("restart_waddr2", 32'(waddr), 32'h2);
    check_output("mid_rf7_after", rf[7], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL set the number of writeback requesters (0 = ALU, 1 = load unit, 2 = debug).
REQ-002 Parameter AW, default 5, SHALL set the register address width.
REQ-003 Parameter DW, default 32, SHALL set the register data width.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 req_valid  input  NREQ  SHALL flag requester i holding a write.
REQ-007 req_waddr  input  NREQ*AW  SHALL carry requester i's destination address in bits [i*AW +: AW].
REQ-008 req_wdata  input  NREQ*DW  SHALL carry requester i's write data in bits [i*DW +: DW].
REQ-009 req_ready  output  NREQ  SHALL be one-hot or zero, marking the requester granted this cycle.
REQ-010 reg_wr  output  1  SHALL drive the register-file write enable.
REQ-011 waddr  output  AW  SHALL drive the register-file write address.
REQ-012 wdata  output  DW  SHALL drive the register-file write data.
REQ-013 init_done  output  1  SHALL be high once the post-reset clear sweep has completed.
REQ-014 grant_id  output  2  SHALL hold the index of the last accepted requester.
REQ-015 x0_drops  output  8  SHALL count writes to address 0 that were suppressed; the count saturates.

Function
REQ-016 The FSM SHALL have two states, INIT and RUN, and SHALL enter INIT on reset.
REQ-017 INIT behaviour:
- A sweep counter SHALL start at 1.
- Each cycle SHALL register reg_wr=1, waddr=counter, wdata=0, then increment the counter.
- After address 31 is issued, the FSM SHALL go to RUN.
- The sweep SHALL take exactly 31 cycles.
REQ-018 In INIT, req_ready SHALL be all zero.
REQ-019 init_done SHALL go high in the first RUN cycle and stay high until reset.
REQ-020 In RUN, arbitration SHALL be round-robin:
- Scan starts at rr_ptr and wraps modulo NREQ.
- The first requester with req_valid=1 SHALL get req_ready=1, combinationally, in the same cycle.
REQ-021 A transfer SHALL occur when req_valid[i] and req_ready[i] are both 1.
REQ-022 Only one transfer SHALL occur per cycle.
REQ-023 On a transfer, rr_ptr SHALL become (i+1) mod NREQ; with no transfer, rr_ptr SHALL hold.
REQ-024 Accepted writes SHALL reach the port with 1-cycle latency: on the next cycle reg_wr=1, waddr=req addr, wdata=req data.
REQ-025 On a cycle with no transfer, reg_wr SHALL be 0 on the next cycle, and waddr and wdata SHALL hold their values.
REQ-026 A transfer to address 0 SHALL still complete the handshake, but the next-cycle reg_wr SHALL be 0.
REQ-027 Each such address-0 transfer SHALL increment x0_drops; x0_drops SHALL saturate at 255.
REQ-028 When several requesters target the same address in one cycle, only the granted one SHALL transfer; the others SHALL wait with no merging.
REQ-029 A requester SHALL keep valid, addr and data stable until its ready; the arbiter SHALL NOT check this.
REQ-030 grant_id SHALL update only on a transfer.

Reset
REQ-031 While reset=1 at a rising edge, the following SHALL apply:
- State = INIT, sweep counter = 1, rr_ptr = 0.
- reg_wr = 0, waddr = 0, wdata = 0.
- init_done = 0, grant_id = 0, x0_drops = 0.
REQ-032 Reset during RUN or mid-sweep SHALL discard the registered in-flight write and restart the full sweep from address 1.
REQ-033 req_ready SHALL be 0 in any cycle where reset=1.

Structure
REQ-034 A shared package SHALL hold the constants AW=5, DW=32 and NREQ=3, the requester index constants, and the INIT/RUN state encoding.
REQ-035 The round-robin picker SHALL be one sub-module, rr_arbiter: inputs request vector and pointer; outputs one-hot grant and index.
REQ-036 The outputs SHALL connect directly to Register_File reg_wr, waddr and wdata; there SHALL be no other storage.

Verification
REQ-037 Sweep: release reset, hold all req_valid=1 -> 31 cycles of reg_wr=1 at waddr 1..31 with wdata=0, req_ready=0 throughout, then init_done=1.
REQ-038 Single write: in RUN, requester 1 writes addr 5 = 0xDEADBEEF -> req_ready[1]=1 that cycle; next cycle reg_wr=1, waddr=5, wdata=0xDEADBEEF; Register_File read of addr 5 returns 0xDEADBEEF.
REQ-039 Fairness: all three requesters continuously valid from rr_ptr=0 -> grants in order 0,1,2,0,1,2 on consecutive cycles, with reg_wr=1 every cycle.
REQ-040 x0 suppression: requester 2 writes addr 0 = 0xFFFFFFFF -> handshake completes, next-cycle reg_wr=0, x0_drops=1, Register_File addr 0 reads 0; 300 such writes -> x0_drops=255.
REQ-041 Collision: requesters 0 and 1 both target addr 3 (0xCAFEBABE, 0x12345678) with rr_ptr=0 -> addr 3 reads 0xCAFEBABE after one cycle, then 0x12345678 after the next.
REQ-042 Reset mid-operation: assert reset the cycle after a transfer to addr 7 -> no write to addr 7 occurs; the sweep restarts at waddr=1.
